// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
// Issue sequencer for a clocked 32-bit ALU with a one-cycle registered output.
// Accepts one operation per valid/ready handshake and decodes alu_op/funct into
// the ALU control code. It drives the operands and waits out the ALU latency.
// It then captures result/zero and presents them, with a branch decision,
// until downstream accepts them.
module alu_issue_ctrl #(
    parameter int          DATA_W    = 32,
    parameter logic [3:0]  IDLE_CTRL = 4'b1111
) (
    input  logic              clk,
    input  logic              rst_n,
    // request side
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic [DATA_W-1:0] operand_a,
    input  logic [DATA_W-1:0] operand_b,
    // ALU side
    output logic [3:0]        alu_control,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    // response side
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              branch_taken,
    output logic              illegal
);

    // ALU control encodings
    localparam logic [3:0] CTRL_AND = 4'b0000;
    localparam logic [3:0] CTRL_OR  = 4'b0001;
    localparam logic [3:0] CTRL_ADD = 4'b0010;
    localparam logic [3:0] CTRL_SUB = 4'b0110;
    localparam logic [3:0] CTRL_SLT = 4'b0111;
    localparam logic [3:0] CTRL_NOR = 4'b1100;

    // R-type function fields
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t     state_reg;
    logic       is_beq_reg;   // remembers the op was a branch compare

    logic [3:0] dec_ctrl;
    logic       dec_illegal;
    logic       dec_swap;     // slt: the ALU tests in2 < in1, so feed rt as in1

    // Decode alu_op/funct into an ALU control code, an illegal flag and a swap flag
    always_comb begin
        dec_ctrl    = IDLE_CTRL;
        dec_illegal = 1'b0;
        dec_swap    = 1'b0;
        case (alu_op)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_SUB;
            2'b10: begin
                case (funct)
                    FN_ADD: dec_ctrl = CTRL_ADD;
                    FN_SUB: dec_ctrl = CTRL_SUB;
                    FN_AND: dec_ctrl = CTRL_AND;
                    FN_OR:  dec_ctrl = CTRL_OR;
                    FN_SLT: begin
                        dec_ctrl = CTRL_SLT;
                        dec_swap = 1'b1;
                    end
                    FN_NOR: dec_ctrl = CTRL_NOR;
                    default: dec_illegal = 1'b1;
                endcase
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Issue FSM: every output is a register, updated only here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            is_beq_reg   <= 1'b0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            alu_control  <= IDLE_CTRL;
            alu_in1      <= '0;
            alu_in2      <= '0;
            result       <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (dec_illegal) begin
                            // The ALU is left untouched; the response is formed here.
                            // out_valid rises one edge later, in RESP.
                            result       <= '0;
                            zero         <= 1'b0;
                            branch_taken <= 1'b0;
                            illegal      <= 1'b1;
                            state_reg    <= RESP;
                        end else begin
                            alu_control <= dec_ctrl;
                            alu_in1     <= dec_swap ? operand_b : operand_a;
                            alu_in2     <= dec_swap ? operand_a : operand_b;
                            is_beq_reg  <= (alu_op == 2'b01);
                            illegal     <= 1'b0;
                            state_reg   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    // ALU samples the held control/operands at this edge
                    state_reg <= CAPT;
                end
                CAPT: begin
                    result       <= alu_result;
                    zero         <= alu_zero;
                    branch_taken <= is_beq_reg & alu_zero;
                    out_valid    <= 1'b1;
                    alu_control  <= IDLE_CTRL;
                    state_reg    <= RESP;
                end
                RESP: begin
                    if (!out_valid) begin
                        // first RESP cycle of an illegal op
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural one-cycle registered ALU.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [3:0]  alu_control;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] alu_result = '0;
    logic        alu_zero = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        branch_taken;
    logic        illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DATA_W(32), .IDLE_CTRL(4'b1111)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_op       (alu_op),
        .funct        (funct),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .alu_control  (alu_control),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .branch_taken (branch_taken),
        .illegal      (illegal)
    );

    // Behavioural ALU: registered output, slt asserts 1 when in2 < in1 (signed)
    logic [31:0] alu_r;
    always @(posedge clk) begin
        case (alu_control)
            4'b0000: alu_r = alu_in1 & alu_in2;
            4'b0001: alu_r = alu_in1 | alu_in2;
            4'b0010: alu_r = alu_in1 + alu_in2;
            4'b0110: alu_r = alu_in1 - alu_in2;
            4'b0111: alu_r = ($signed(alu_in2) < $signed(alu_in1)) ? 32'd1 : 32'd0;
            4'b1100: alu_r = ~(alu_in1 | alu_in2);
            default: alu_r = 32'd0;
        endcase
        alu_result <= alu_r;
        alu_zero   <= (alu_control == 4'b0110) && (alu_r == 32'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op starting just after a clock edge; check latency, hold and completion.
    task automatic do_op(input string name, input logic [1:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b, input logic ill,
                         input logic [3:0] ectrl, input logic [31:0] ein1, input logic [31:0] ein2,
                         input logic [31:0] eres, input logic ez, input logic ebr, input int hold);
        in_valid  = 1'b1;
        alu_op    = op;
        funct     = fn;
        operand_a = a;
        operand_b = b;
        @(posedge clk); #1;                       // edge N
        in_valid = 1'b0;
        chk({name, ":in_ready_N"}, 32'(in_ready), 32'd0);
        chk({name, ":out_valid_N"}, 32'(out_valid), 32'd0);
        chk({name, ":ctrl_N"}, 32'(alu_control), ill ? 32'hF : 32'(ectrl));
        if (!ill) begin
            chk({name, ":in1"}, alu_in1, ein1);
            chk({name, ":in2"}, alu_in2, ein2);
            @(posedge clk); #1;                   // edge N+1
            chk({name, ":out_valid_N1"}, 32'(out_valid), 32'd0);
            chk({name, ":ctrl_N1"}, 32'(alu_control), 32'(ectrl));
        end
        @(posedge clk); #1;                       // N+2 legal, N+1 illegal
        chk({name, ":out_valid"}, 32'(out_valid), 32'd1);
        chk({name, ":result"}, result, eres);
        chk({name, ":zero"}, 32'(zero), 32'(ez));
        chk({name, ":branch"}, 32'(branch_taken), 32'(ebr));
        chk({name, ":illegal"}, 32'(illegal), 32'(ill));
        chk({name, ":ctrl_idle"}, 32'(alu_control), 32'hF);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            alu_op   = 2'b00;
            @(posedge clk); #1;
            chk({name, ":hold_valid"}, 32'(out_valid), 32'd1);
            chk({name, ":hold_result"}, result, eres);
            chk({name, ":hold_ready"}, 32'(in_ready), 32'd0);
            chk({name, ":hold_ctrl"}, 32'(alu_control), 32'hF);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, ":done_valid"}, 32'(out_valid), 32'd0);
        chk({name, ":done_ready"}, 32'(in_ready), 32'd1);
        chk({name, ":done_result"}, result, eres);
        $display("op %s a=%h b=%h result=%h zero=%0d br=%0d ill=%0d",
                 name, a, b, result, zero, branch_taken, illegal);
    endtask

    task automatic chk_reset(input string name);
        chk({name, ":in_ready"}, 32'(in_ready), 32'd1);
        chk({name, ":out_valid"}, 32'(out_valid), 32'd0);
        chk({name, ":ctrl"}, 32'(alu_control), 32'hF);
        chk({name, ":in1"}, alu_in1, 32'd0);
        chk({name, ":in2"}, alu_in2, 32'd0);
        chk({name, ":result"}, result, 32'd0);
        chk({name, ":zero"}, 32'(zero), 32'd0);
        chk({name, ":branch"}, 32'(branch_taken), 32'd0);
        chk({name, ":illegal"}, 32'(illegal), 32'd0);
        $display("reset check %s", name);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_op    = 2'b00;
        funct     = 6'd0;
        operand_a = '0;
        operand_b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst0");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // load/store add
        do_op("add",  2'b00, 6'd0, 32'd5, -32'sd3, 1'b0, 4'b0010, 32'd5, -32'sd3, 32'd2, 1'b0, 1'b0, 0);
        // beq equal / not equal
        do_op("beq_eq", 2'b01, 6'd0, 32'd7, 32'd7, 1'b0, 4'b0110, 32'd7, 32'd7, 32'd0, 1'b1, 1'b1, 0);
        do_op("beq_ne", 2'b01, 6'd0, 32'd7, 32'd8, 1'b0, 4'b0110, 32'd7, 32'd8, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
        // R-type sweep
        do_op("r_and", 2'b10, 6'b100100, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 4'b0000,
              32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0, 0);
        do_op("r_or",  2'b10, 6'b100101, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 4'b0001,
              32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 1'b0, 0);
        do_op("r_nor", 2'b10, 6'b100111, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 4'b1100,
              32'h0000_F0F0, 32'h0000_0FF0, 32'hFFFF_000F, 1'b0, 1'b0, 0);
        do_op("r_add", 2'b10, 6'b100000, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 4'b0010,
              32'h0000_F0F0, 32'h0000_0FF0, 32'h0001_00E0, 1'b0, 1'b0, 0);
        do_op("r_sub", 2'b10, 6'b100010, 32'h0000_F0F0, 32'h0000_0FF0, 1'b0, 4'b0110,
              32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_E100, 1'b0, 1'b0, 0);
        do_op("slt_lt", 2'b10, 6'b101010, -32'sd2, 32'd1, 1'b0, 4'b0111,
              32'd1, -32'sd2, 32'd1, 1'b0, 1'b0, 0);
        do_op("slt_ge", 2'b10, 6'b101010, 32'd1, -32'sd2, 1'b0, 4'b0111,
              -32'sd2, 32'd1, 32'd0, 1'b0, 1'b0, 0);
        // illegal ops: out_valid one edge after accept, ALU never driven
        do_op("ill_fn", 2'b10, 6'b000000, 32'd3, 32'd4, 1'b1, 4'b1111, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0);
        chk("ill_fn:in1_untouched", alu_in1, -32'sd2);
        do_op("ill_op", 2'b11, 6'b100000, 32'd3, 32'd4, 1'b1, 4'b1111, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 0);
        // backpressure with ignored in_valid pulses
        do_op("bp_add", 2'b00, 6'd0, 32'd100, 32'd23, 1'b0, 4'b0010, 32'd100, 32'd23, 32'd123, 1'b0, 1'b0, 5);

        // reset while in EXEC discards the operation
        in_valid  = 1'b1;
        alu_op    = 2'b00;
        operand_a = 32'd9;
        operand_b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_exec:accepted", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        #2;
        chk_reset("rst_exec");
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rst_exec:no_resp", 32'(out_valid), 32'd0);
            chk("rst_exec:ready", 32'(in_ready), 32'd1);
        end
        do_op("post_rst", 2'b00, 6'd0, 32'd40, 32'd2, 1'b0, 4'b0010, 32'd40, 32'd2, 32'd42, 1'b0, 1'b0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: the directed sequence is short; stop hard if it ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
